// File: rtl/core_wb_arbiter_pkg.sv
// core_wb_arbiter_pkg: shared state encodings and requester IDs for the core Wishbone arbiter
package core_wb_arbiter_pkg;
  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_GRANT_DATA  = 2'd1,
    ST_GRANT_FETCH = 2'd2,
    ST_RELEASE     = 2'd3
  } state_e;
  localparam logic REQ_DATA  = 1'b0;
  localparam logic REQ_FETCH = 1'b1;
endpackage

// File: rtl/core_wb_arbiter.sv
// core_wb_arbiter: round-robin arbiter sharing one Wishbone master port between fetch and data requesters
module core_wb_arbiter
  import core_wb_arbiter_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 28,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic [ADDRESS_WIDTH-1:0] fetchAddress,
  input  logic [3:0]               fetchByteSelect,
  input  logic                     fetchEnable,
  input  logic                     fetchWriteEnable,
  input  logic [31:0]              fetchDataWrite,
  output logic [31:0]              fetchDataRead,
  output logic                     fetchBusy,
  output logic                     fetchError,
  input  logic [ADDRESS_WIDTH-1:0] dataAddress,
  input  logic [3:0]               dataByteSelect,
  input  logic                     dataEnable,
  input  logic                     dataWriteEnable,
  input  logic [31:0]              dataDataWrite,
  output logic [31:0]              dataDataRead,
  output logic                     dataBusy,
  output logic                     dataError,
  output logic [ADDRESS_WIDTH-1:0] wbAddress,
  output logic [3:0]               wbByteSelect,
  output logic                     wbEnable,
  output logic                     wbWriteEnable,
  output logic [31:0]              wbDataWrite,
  input  logic [31:0]              wbDataRead,
  input  logic                     wbBusy
);
  // The wait counter times out on the cycle it would reach TIMEOUT_CYCLES, giving exactly TIMEOUT_CYCLES grant cycles.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);
  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        tout_q, tout_d;
  logic [31:0] drd_q, drd_d;
  logic [31:0] frd_q, frd_d;
  logic        in_grant, gnt_fetch, gnt_en, rel, load;
  logic [31:0] load_val;
  assign in_grant      = state_q == ST_GRANT_DATA || state_q == ST_GRANT_FETCH;
  assign gnt_fetch     = state_q == ST_GRANT_FETCH;
  assign rel           = state_q == ST_RELEASE;
  assign gnt_en        = gnt_fetch ? fetchEnable : dataEnable;
  assign wbEnable      = in_grant && gnt_en;
  assign wbAddress     = gnt_fetch ? fetchAddress : dataAddress;
  assign wbByteSelect  = gnt_fetch ? fetchByteSelect : dataByteSelect;
  assign wbWriteEnable = gnt_fetch ? fetchWriteEnable : dataWriteEnable;
  assign wbDataWrite   = gnt_fetch ? fetchDataWrite : dataDataWrite;
  // last_q names the granted requester throughout GRANT and RELEASE, so it steers the release-cycle handshake.
  assign dataBusy      = dataEnable && !(rel && done_q && last_q == REQ_DATA);
  assign fetchBusy     = fetchEnable && !(rel && done_q && last_q == REQ_FETCH);
  assign dataError     = rel && tout_q && last_q == REQ_DATA;
  assign fetchError    = rel && tout_q && last_q == REQ_FETCH;
  assign dataDataRead  = drd_q;
  assign fetchDataRead = frd_q;
  // Next state: round-robin grant from IDLE, completion/timeout/abandon in GRANT, one-cycle RELEASE.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    tout_d   = 1'b0;
    load     = 1'b0;
    load_val = '1;
    case (state_q)
      ST_IDLE:
        if (dataEnable && (!fetchEnable || last_q == REQ_FETCH)) begin
          state_d = ST_GRANT_DATA;
          last_d  = REQ_DATA;
          cnt_d   = '0;
        end else if (fetchEnable) begin
          state_d = ST_GRANT_FETCH;
          last_d  = REQ_FETCH;
          cnt_d   = '0;
        end
      ST_GRANT_DATA, ST_GRANT_FETCH:
        if (!gnt_en) begin
          state_d = ST_RELEASE;
        end else if (!wbBusy) begin
          state_d  = ST_RELEASE;
          done_d   = 1'b1;
          load     = 1'b1;
          load_val = wbWriteEnable ? '1 : wbDataRead;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_RELEASE;
          done_d  = 1'b1;
          tout_d  = 1'b1;
          load    = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end
  // Read-data registers load only on their own requester's completion or timeout.
  always_comb begin
    drd_d = (load && !gnt_fetch) ? load_val : drd_q;
    frd_d = (load && gnt_fetch) ? load_val : frd_q;
  end
  // State and data registers with synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      last_q  <= REQ_FETCH;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      tout_q  <= 1'b0;
      drd_q   <= '1;
      frd_q   <= '1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      tout_q  <= tout_d;
      drd_q   <= drd_d;
      frd_q   <= frd_d;
    end
  end
endmodule

// File: tb/tb_core_wb_arbiter.sv
// tb_core_wb_arbiter: scoreboard bench for core_wb_arbiter with directed transactions
module tb_core_wb_arbiter;
  typedef struct packed {logic [31:0] rd; logic err; logic [7:0] lat;} rsp_t;
  typedef struct packed {logic [27:0] a; logic [3:0] s; logic w; logic [31:0] d;} wbt_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [27:0] f_addr = '0, d_addr = '0, wb_addr;
  logic [3:0] f_sel = '0, d_sel = '0, wb_sel;
  logic f_en = 1'b0, d_en = 1'b0, f_we = 1'b0, d_we = 1'b0;
  logic [31:0] f_wd = '0, d_wd = '0, f_rd, d_rd, wb_wd;
  logic f_busy, d_busy, f_err, d_err, wb_en, wb_we, wb_busy;
  logic [31:0] ds_data = '0;
  int ds_lat = 0, ds_cnt = 0, cyc = 0, g_cyc = 0;
  logic hang = 1'b0, prev_en = 1'b0, prev_done = 1'b0;
  int tests = 0, fails = 0;
  rsp_t rsp_d[$], rsp_f[$], r;
  wbt_t wbq[$], w;
  core_wb_arbiter #(.ADDRESS_WIDTH(28), .TIMEOUT_CYCLES(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .fetchAddress(f_addr), .fetchByteSelect(f_sel), .fetchEnable(f_en), .fetchWriteEnable(f_we),
    .fetchDataWrite(f_wd), .fetchDataRead(f_rd), .fetchBusy(f_busy), .fetchError(f_err),
    .dataAddress(d_addr), .dataByteSelect(d_sel), .dataEnable(d_en), .dataWriteEnable(d_we),
    .dataDataWrite(d_wd), .dataDataRead(d_rd), .dataBusy(d_busy), .dataError(d_err),
    .wbAddress(wb_addr), .wbByteSelect(wb_sel), .wbEnable(wb_en), .wbWriteEnable(wb_we),
    .wbDataWrite(wb_wd), .wbDataRead(ds_data), .wbBusy(wb_busy)
  );
  always #5 clk = ~clk;
  assign wb_busy = hang || ds_cnt != ds_lat;
  // Downstream slave: completes on the ds_lat-th cycle (0-based) of a continuous enable.
  always @(posedge clk) begin
    ds_cnt <= wb_en ? ds_cnt + 1 : 0;
    cyc <= cyc + 1;
  end
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic exp_rsp(input logic f, input logic [31:0] rd, input logic err, input logic [7:0] lat);
    if (f) rsp_f.push_back({rd, err, lat});
    else rsp_d.push_back({rd, err, lat});
  endtask
  task automatic exp_wb(input logic [27:0] a, input logic [3:0] s, input logic wr, input logic [31:0] d);
    wbq.push_back({a, s, wr, d});
  endtask
  task automatic req(input logic f, input logic [27:0] a, input logic [3:0] s, input logic wr, input logic [31:0] wd);
    logic ok = 1'b0;
    if (f) begin f_addr = a; f_sel = s; f_we = wr; f_wd = wd; f_en = 1'b1; end
    else begin d_addr = a; d_sel = s; d_we = wr; d_wd = wd; d_en = 1'b1; end
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      ok = f ? !f_busy : !d_busy;
    end
    chk(f ? "fetch_done" : "data_done", ok, 1);
    tick();
    if (f) f_en = 1'b0;
    else d_en = 1'b0;
  endtask
  // Monitor: checks downstream transfers, the release gap and requester completions against the queues.
  always @(negedge clk) begin
    if (wb_en && !prev_en) g_cyc = cyc;
    if (prev_done) chk("release_wb_en", wb_en, 0);
    if (wb_en && !wb_busy) begin
      if (wbq.size() == 0) begin
        tests++; fails++;
        $display("FAIL wb_unexpected: got addr %0h expected no transfer", wb_addr);
      end else begin
        w = wbq.pop_front();
        chk("wb_addr", wb_addr, w.a);
        chk("wb_sel", wb_sel, w.s);
        chk("wb_we", wb_we, w.w);
        if (w.w) chk("wb_wdata", wb_wd, w.d);
      end
    end
    prev_done = wb_en && !wb_busy;
    prev_en = wb_en;
    if (!rst) begin
      chk("d_busy_idle", d_busy & ~d_en, 0);
      chk("f_busy_idle", f_busy & ~f_en, 0);
      chk("d_err_busy", d_err & (d_busy | ~d_en), 0);
      chk("f_err_busy", f_err & (f_busy | ~f_en), 0);
      if (d_en && !d_busy) begin
        if (rsp_d.size() == 0) begin
          tests++; fails++;
          $display("FAIL d_unexpected: got completion rd %0h expected none", d_rd);
        end else begin
          r = rsp_d.pop_front();
          chk("d_rd", d_rd, r.rd);
          chk("d_err", d_err, r.err);
          chk("d_lat", cyc - g_cyc, r.lat);
        end
      end
      if (f_en && !f_busy) begin
        if (rsp_f.size() == 0) begin
          tests++; fails++;
          $display("FAIL f_unexpected: got completion rd %0h expected none", f_rd);
        end else begin
          r = rsp_f.pop_front();
          chk("f_rd", f_rd, r.rd);
          chk("f_err", f_err, r.err);
          chk("f_lat", cyc - g_cyc, r.lat);
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wb_en", wb_en, 0);
    chk("rst_d_rd", d_rd, 32'hFFFFFFFF);
    chk("rst_f_rd", f_rd, 32'hFFFFFFFF);
    chk("rst_d_err", d_err, 0);
    chk("rst_f_err", f_err, 0);
    tick();
    rst = 1'b0;
    tick();
    // Contention from reset: data first, then fetch.
    ds_lat = 2; ds_data = 32'h11110000;
    exp_wb(28'h0000200, 4'hF, 0, 0); exp_wb(28'h0000300, 4'hF, 0, 0);
    exp_rsp(0, 32'h11110000, 0, 3); exp_rsp(1, 32'h11110000, 0, 3);
    fork
      req(0, 28'h0000200, 4'hF, 0, 0);
      req(1, 28'h0000300, 4'hF, 0, 0);
    join
    tick();
    // Single data read; completion coincides with the timeout count and must win.
    ds_lat = 3; ds_data = 32'hDEADBEEF;
    exp_wb(28'h0000100, 4'hF, 0, 0);
    exp_rsp(0, 32'hDEADBEEF, 0, 4);
    req(0, 28'h0000100, 4'hF, 0, 0);
    tick();
    // Contention after a data grant: fetch first.
    ds_lat = 0; ds_data = 32'h0BADF00D;
    exp_wb(28'h0000310, 4'hF, 0, 0); exp_wb(28'h0000210, 4'hF, 0, 0);
    exp_rsp(1, 32'h0BADF00D, 0, 1); exp_rsp(0, 32'h0BADF00D, 0, 1);
    fork
      req(0, 28'h0000210, 4'hF, 0, 0);
      req(1, 28'h0000310, 4'hF, 0, 0);
    join
    tick();
    // Fetch granted, abandons after 2 cycles; data is then granted.
    ds_data = 32'h600DCAFE;
    exp_wb(28'h0000500, 4'hF, 0, 0);
    exp_rsp(0, 32'h600DCAFE, 0, 2);
    fork
      begin
        f_addr = 28'h0000400; f_sel = 4'hF; f_we = 1'b0; f_en = 1'b1; hang = 1'b1;
        repeat (3) tick();
        f_en = 1'b0; hang = 1'b0; ds_lat = 1;
      end
      req(0, 28'h0000500, 4'hF, 0, 0);
    join
    chk("f_rd_hold", f_rd, 32'h0BADF00D);
    tick();
    // Data write: downstream sees address/data/sel, read data becomes all-ones.
    ds_lat = 1; ds_data = 32'h77777777;
    exp_wb(28'hABCDEF0, 4'h3, 1, 32'h12345678);
    exp_rsp(0, 32'hFFFFFFFF, 0, 2);
    req(0, 28'hABCDEF0, 4'h3, 1, 32'h12345678);
    tick();
    // Fetch timeout after 4 grant cycles.
    hang = 1'b1;
    exp_rsp(1, 32'hFFFFFFFF, 1, 4);
    req(1, 28'h0000800, 4'hF, 0, 0);
    hang = 1'b0;
    tick();
    ds_lat = 0; ds_data = 32'hC0FFEE01;
    exp_wb(28'h0000610, 4'h1, 0, 0);
    exp_rsp(0, 32'hC0FFEE01, 0, 1);
    req(0, 28'h0000610, 4'h1, 0, 0);
    tick();
    ds_data = 32'hCAFEF00D;
    exp_wb(28'h0000710, 4'hC, 0, 0);
    exp_rsp(1, 32'hCAFEF00D, 0, 1);
    req(1, 28'h0000710, 4'hC, 0, 0);
    tick();
    // One-cycle reset mid-grant aborts the transfer.
    d_addr = 28'h0000900; d_sel = 4'hF; d_we = 1'b0; d_en = 1'b1; hang = 1'b1;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_wb_en", wb_en, 0);
    chk("rst2_d_rd", d_rd, 32'hFFFFFFFF);
    chk("rst2_f_rd", f_rd, 32'hFFFFFFFF);
    chk("rst2_d_err", d_err, 0);
    d_en = 1'b0; hang = 1'b0;
    repeat (3) tick();
    chk("left_rsp_d", rsp_d.size(), 0);
    chk("left_rsp_f", rsp_f.size(), 0);
    chk("left_wbq", wbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/core_wb_arbiter.md
CORE_WB_ARBITER -- requirements
Module: core_wb_arbiter

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 28: address width of every port.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, range 1..255: maximum cycles a grant waits for completion.
REQ-003 wb_clk_i  in  1  single clock; all logic on its rising edge.
REQ-004 wb_rst_i  in  1  reset, synchronous and active-high.
REQ-005 fetchAddress / dataAddress  in  ADDRESS_WIDTH  requester word address.
REQ-006 fetchByteSelect / dataByteSelect  in  4  requester byte lanes.
REQ-007 fetchEnable / dataEnable  in  1  request; held high until completion.
REQ-008 fetchWriteEnable / dataWriteEnable  in  1  1 = write, 0 = read.
REQ-009 fetchDataWrite / dataDataWrite  in  32  write data.
REQ-010 fetchDataRead / dataDataRead  out  32  registered read data.
REQ-011 fetchBusy / dataBusy  out  1  0 = completion, or requester idle.
REQ-012 fetchError / dataError  out  1  one-cycle timeout pulse.
REQ-013 wbAddress, wbByteSelect, wbEnable, wbWriteEnable, wbDataWrite  out  ADDRESS_WIDTH/4/1/1/32  shared port to the Wishbone master interface.
REQ-014 wbDataRead  in  32;  wbBusy  in  1  (wbBusy=0 while wbEnable=1 = transaction complete).

Function
REQ-015 States: IDLE, GRANT_DATA, GRANT_FETCH, RELEASE; 2-bit encoding; illegal codes SHALL go to IDLE.
REQ-016 IDLE: no request -> stay; one request -> GRANT of that requester; both -> round-robin, granting the requester not granted last.
REQ-017 The lastGrant register SHALL update on each IDLE->GRANT transition.
REQ-018 wbEnable SHALL be 1 only in GRANT_x while the granted requester's enable is 1.
REQ-019 wbAddress/ByteSelect/WriteEnable/DataWrite SHALL mux combinationally from the granted requester.
REQ-020 In GRANT_x, completion is wbBusy=0 with wbEnable=1: latch wbDataRead into that requester's DataRead; go to RELEASE.
REQ-021 RELEASE lasts exactly one cycle with wbEnable=0, then goes to IDLE; this guarantees the shared port sees enable low between transactions and never re-launches a transaction.
REQ-022 In RELEASE following a completion, the granted requester's Busy SHALL be 0; requester-visible latency = downstream latency + 1.
REQ-023 Busy SHALL be 1 whenever the requester's enable is 1, except in its completion cycle; Busy SHALL be 0 when enable is 0.
REQ-024 DataRead SHALL hold its value until that requester's next completion; a write completion SHALL load all-ones.
REQ-025 An 8-bit wait counter SHALL clear on entry to GRANT_x and increment each GRANT cycle without completion.
REQ-026 When the counter reaches TIMEOUT_CYCLES: go to RELEASE, load DataRead with all-ones, and in RELEASE pulse Error=1 with Busy=0.
REQ-027 If the granted requester drops its enable during GRANT: go to RELEASE with no completion, no data update and no error.
REQ-028 When completion and timeout occur in the same cycle, completion SHALL win.
REQ-029 A requester not granted SHALL be stalled (Busy=1) with its outputs unchanged.

Reset
REQ-030 During reset: state=IDLE, lastGrant=FETCH (data wins the first contention), counter=0, both DataRead=all-ones, Error=0, wbEnable=0.
REQ-031 Reset asserted mid-transaction SHALL abort it at the next edge, with no completion or error pulse.

Structure
REQ-032 State encodings and the requester-ID constants (DATA=0, FETCH=1) SHALL live in the shared core Wishbone package.
REQ-033 The block SHALL be a single flat module with no sub-modules.

Verification
REQ-034 Single data read to 0x0000100: downstream completes after 3 cycles with 0xDEADBEEF -> dataBusy low 4 cycles after grant, dataDataRead=0xDEADBEEF, one RELEASE cycle with wbEnable=0.
REQ-035 Fetch and data both request from reset -> data granted first, then fetch; a repeat contention grants fetch first.
REQ-036 Data write of 0x12345678 with byteSelect 0x3 -> downstream sees the same address, data and sel, with wbWriteEnable=1; dataDataRead=all-ones afterwards.
REQ-037 TIMEOUT_CYCLES=4 with wbBusy held high -> after 4 GRANT cycles: fetchError pulses 1 cycle, fetchBusy=0, fetchDataRead=0xFFFFFFFF.
REQ-038 Granted requester drops enable after 2 cycles -> RELEASE with no Error and DataRead unchanged; the other requester is then granted.
REQ-039 wb_rst_i asserted for 1 cycle mid-GRANT -> next cycle: state IDLE, wbEnable=0, both DataRead=0xFFFFFFFF.
